// File: rtl/fxp_neuron_accumulator.sv
// Streaming signed fixed-point accumulator for one neuron: sums up to TERMS terms
// at full precision, then holds one saturated or wrapped DATA_W+1 bit result.
module fxp_neuron_accumulator #(
  parameter int DATA_W = 12,
  parameter int FRAC_W = 6,
  parameter int TERMS  = 4,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W:0]   out_sum,
  output logic                     out_ovf
);

  localparam int R     = DATA_W + 1;
  localparam int ACC_W = DATA_W + $clog2(TERMS) + 1;
  localparam int CNT_W = $clog2(TERMS) + 1;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  if (TERMS < 2 || FRAC_W >= DATA_W) begin : g_bad_params
    $error("fxp_neuron_accumulator: TERMS must be >= 2 and FRAC_W < DATA_W");
  end

  logic [0:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;

  logic signed [ACC_W-1:0] sum_s;
  logic [ACC_W-R:0]        sum_hi;
  logic                    in_range;
  logic                    is_final;
  logic signed [R-1:0]     res;
  logic                    res_ovf;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  assign sum_s    = acc + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign is_final = in_last || (cnt == CNT_W'(TERMS - 1));

  // The sum fits R signed bits exactly when every bit from R-1 upward matches the sign.
  assign sum_hi   = sum_s[ACC_W-1:R-1];
  assign in_range = (&sum_hi) | (~|sum_hi);

  always_comb begin
    res     = sum_s[R-1:0];
    res_ovf = !in_range;
    if (SAT_EN && !in_range) begin
      res = sum_s[ACC_W-1] ? {1'b1, {(R-1){1'b0}}} : {1'b0, {(R-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (is_final) begin
              out_sum <= res;
              out_ovf <= res_ovf;
              acc     <= '0;
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              acc <= sum_s;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_neuron_accumulator.sv
// Directed bench for fxp_neuron_accumulator: a saturating and a wrapping instance
// share one stimulus stream; expected sums are worked out by hand in Q5.6.
module tb_fxp_neuron_accumulator;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b1;
  logic signed [11:0] in_data = '0;

  logic              in_ready, out_valid, out_ovf;
  logic signed [12:0] out_sum;
  logic              in_ready_w, out_valid_w, out_ovf_w;
  logic signed [12:0] out_sum_w;

  int checks = 0;
  int failures = 0;

  fxp_neuron_accumulator #(.DATA_W(12), .FRAC_W(6), .TERMS(4), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  fxp_neuron_accumulator #(.DATA_W(12), .FRAC_W(6), .TERMS(4), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_sum(out_sum_w), .out_ovf(out_ovf_w)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Called on a falling edge; presents one term and returns on the falling edge after it is taken.
  task automatic applyStimulus(input int data, input bit last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = 12'(data);
    in_last  = last;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic sendGroup(input int data);
    for (int i = 0; i < 4; i++) applyStimulus(data, 1'b0);
  endtask

  // Checks the held result, lets out_ready=1 consume it and checks out_valid drops.
  task automatic checkResult(input string tag, input int exp_sum, input int exp_ovf);
    checkOutput({tag, "_valid"}, int'(out_valid), 1);
    checkOutput({tag, "_sum"}, int'(out_sum), exp_sum);
    checkOutput({tag, "_ovf"}, int'(out_ovf), exp_ovf);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_drop"}, int'(out_valid), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_sum", int'(out_sum), 0);
    checkOutput("rst_out_ovf", int'(out_ovf), 0);
    checkOutput("rst_wrap_ready", int'(in_ready_w), 1);
    rst = 1'b0;
    @(negedge clk);

    // Basic group: 208+112-160+64 = 224 (3.5)
    applyStimulus(208, 1'b0);
    applyStimulus(112, 1'b0);
    applyStimulus(-160, 1'b0);
    checkOutput("basic_not_early", int'(out_valid), 0);
    applyStimulus(64, 1'b0);
    checkOutput("basic_wrap_valid", int'(out_valid_w), 1);
    checkResult("basic", 224, 0);

    // Positive overflow: 4*2047 = 8188; clamps to 4095, wraps to -4
    sendGroup(2047);
    checkOutput("possat_wrap_sum", int'(out_sum_w), -4);
    checkOutput("possat_wrap_ovf", int'(out_ovf_w), 1);
    checkResult("possat", 4095, 1);

    // Negative overflow: 4*-2048 = -8192; clamps to -4096, wraps to 0
    sendGroup(-2048);
    checkOutput("negsat_wrap_sum", int'(out_sum_w), 0);
    checkOutput("negsat_wrap_ovf", int'(out_ovf_w), 1);
    checkResult("negsat", -4096, 1);
    sendGroup(64);
    checkResult("after_negsat", 256, 0);

    // Early close after two terms, then a full group
    applyStimulus(992, 1'b0);
    applyStimulus(-992, 1'b1);
    checkResult("early", 0, 0);
    sendGroup(64);
    checkResult("after_early", 256, 0);

    // in_last on the very first term
    applyStimulus(-5, 1'b1);
    checkResult("first_last", -5, 0);

    // in_last coinciding with the fourth term: 10+10+10+20
    applyStimulus(10, 1'b0);
    applyStimulus(10, 1'b0);
    applyStimulus(10, 1'b0);
    applyStimulus(20, 1'b1);
    checkResult("last_at_max", 50, 0);

    // Gaps between terms and backpressure in HOLD
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(64, 1'b0);
      if (i < 3) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = 12'sd128;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", int'(out_valid), 1);
      checkOutput("bp_in_ready", int'(in_ready), 0);
      checkOutput("bp_sum", int'(out_sum), 256);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_ready_back", int'(in_ready), 1);
    checkOutput("bp_valid_drop", int'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    applyStimulus(64, 1'b0);
    applyStimulus(64, 1'b0);
    applyStimulus(64, 1'b0);
    checkResult("bp_held_term", 320, 0);

    // Reset mid-group discards the partial sum and clears the held result
    applyStimulus(1000, 1'b0);
    applyStimulus(1000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", int'(out_valid), 0);
    checkOutput("midrst_sum", int'(out_sum), 0);
    checkOutput("midrst_ovf", int'(out_ovf), 0);
    checkOutput("midrst_ready", int'(in_ready), 1);
    rst = 1'b0;
    sendGroup(64);
    checkResult("after_midrst", 256, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fxp_neuron_accumulator.md
# fxp_neuron_accumulator

Parametrised, sequential successor to the Simple_neuron single-shot Q-format adder. It accepts a stream of signed fixed-point terms through a valid/ready handshake and accumulates up to TERMS of them in a full-precision register. It then emits one result, saturated (or wrapped) to DATA_W+1 bits, with an overflow flag. It sits between the multiplier/weight stage and the activation stage of a neuron.

## Interface
- DATA_W, 12: input term width in bits, signed two's complement. Default is Q5.6.
- FRAC_W, 6: fractional bits. Informational only; the result carries the same binary point as the input.
- TERMS, 4: maximum number of terms per result, ≥2.
- SAT_EN, 1: overflow mode.
  - 1: clamp to the output range.
  - 0: wrap modulo 2^(DATA_W+1).
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: a term is presented.
- in_ready  out  1: the block accepts a term this cycle.
- in_data  in  DATA_W: signed term.
- in_last  in  1: the current term closes the group early.
- out_valid  out  1: a result is held.
- out_ready  in  1: the consumer takes the result.
- out_sum  out  DATA_W+1: signed result, same binary point.
- out_ovf  out  1: the result was clamped (SAT_EN=1) or wrapped (SAT_EN=0).

## Operation
- Internal accumulator `acc` is ACC_W = DATA_W+clog2(TERMS)+1 bits, signed. It never overflows internally.
- Term counter `cnt` is clog2(TERMS)+1 bits wide.
- Input handshake occurs when in_valid && in_ready.

**State ACCUM**
- Outputs: in_ready=1, out_valid=0.
- On each handshake: acc ← acc + sign_extend(in_data), cnt ← cnt+1.
- A handshake with in_last=1 or cnt==TERMS-1 is the final term. On the final term:
  - Compute the final sum s = acc + sext(in_data).
  - Register out_sum and out_ovf from s (rules below).
  - Clear acc and cnt.
  - Go to HOLD.

**State HOLD**
- Outputs: in_ready=0, out_valid=1.
- out_sum and out_ovf are stable.
- When out_ready=1: go to ACCUM. out_valid drops the next cycle.

**Width rules, with R = DATA_W+1**
- SAT_EN=1:
  - s > 2^(R-1)-1 → out_sum = 2^(R-1)-1, out_ovf=1.
  - s < -2^(R-1) → out_sum = -2^(R-1), out_ovf=1.
  - Otherwise out_sum = s[R-1:0], out_ovf=0.
- SAT_EN=0:
  - out_sum = s[R-1:0].
  - out_ovf=1 iff s lies outside the R-bit signed range.
- Never invert or otherwise sign-manipulate the result; two's complement is preserved.

**Boundary conditions**
- in_valid low in ACCUM: hold acc and cnt. Gaps between terms are allowed.
- in_last on the very first term: the result equals that term, sign-extended.
- in_last together with cnt==TERMS-1: a single final term with no double-close.
- in_valid while in HOLD: not accepted. The upstream source must hold its data until in_ready returns.
- rst at any cycle, including mid-group or in HOLD:
  - Next state is ACCUM, with acc=0 and cnt=0.
  - out_valid=0, out_sum=0, out_ovf=0.
  - The partial group is discarded.

## Timing
- Reset values: state=ACCUM, in_ready=1, out_valid=0, out_sum=0, out_ovf=0, acc=0, cnt=0.
- Latency: out_valid rises on the edge that accepts the final term, i.e. it is visible the cycle after the final handshake.
- in_ready is a registered function of state only. There is no combinational path from in_valid or out_ready to in_ready.
- Throughput: one term per cycle in ACCUM, plus at least one HOLD cycle per result. Minimum period for a full group is TERMS+1 cycles when out_ready is held high.
- out_sum and out_ovf change only on entry to HOLD or on rst.

## Test plan
- Test plan parameters: DATA_W=12, FRAC_W=6, TERMS=4, SAT_EN=1, unless stated otherwise.

1. **Basic group.**
   - Stimulus: 3.25, 1.75, -2.5, 1.0 (208, 112, -160, 64) back-to-back, out_ready=1.
   - Required: out_valid for 1 cycle, starting the cycle after the 4th handshake; out_sum=224 (3.5); out_ovf=0.
2. **Positive saturation.**
   - Stimulus: four terms of 2047 (31.984375).
   - Required: out_sum=4095, out_ovf=1.
   - Same stimulus with SAT_EN=0: out_sum=-4, out_ovf=1.
3. **Negative saturation.**
   - Stimulus: four terms of -2048 (-32.0).
   - Required: out_sum=-4096, out_ovf=1.
   - Follow with four terms of 64: out_sum=256, out_ovf=0. This proves acc was cleared.
4. **Early close.**
   - Stimulus: 15.5 (992), then -15.5 (-992) with in_last=1.
   - Required: out_sum=0 after 2 terms, out_ovf=0.
   - The next group of four terms of 64 gives 256.
5. **Backpressure and gaps.**
   - Stimulus: in_valid toggles 1/0 during a group of 4×64; out_ready held 0 for 5 cycles after out_valid rises.
   - Required:
     - out_sum=256, stable while out_valid=1.
     - in_ready=0 throughout HOLD, and a term held on in_data is not consumed.
     - That term is accepted the cycle after out_ready=1 drops the block back to ACCUM.
6. **Reset mid-group.**
   - Stimulus: accept 2 terms of 1000, pulse rst for 1 cycle, then send 4 terms of 64.
   - Required: all outputs are 0 during the reset cycle; the next result is out_sum=256, out_ovf=0.
